// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl: pipeline write-enable/flush sequencing for load-use stalls, taken branches and dmem waits
module hazard_stall_ctrl #(
  parameter int LOAD_USE_BUBBLES = 2,
  parameter int MEM_TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  inst_curr_IFID_7_4_rs,
  input  logic [3:0]  inst_curr_IFID_3_0_rt,
  input  logic [3:0]  inst_curr_IFID_11_8_rd,
  input  logic        rt_used_ifid,
  input  logic        store_ifid,
  input  logic [3:0]  rf_waddr_idex,
  input  logic        rf_wen_idex,
  input  logic        mem2reg_idex,
  input  logic        branch_taken_ex,
  input  logic        dmem_req,
  input  logic        dmem_ack,
  output logic        pc_wen,
  output logic        ifid_wen,
  output logic        idex_wen,
  output logic        exmem_wen,
  output logic        memwb_wen,
  output logic        ifid_flush,
  output logic        idex_flush,
  output logic        pc_sel_branch,
  output logic [15:0] stall_cycles,
  output logic        mem_timeout
);
  typedef enum logic {RUN, LSTALL} state_t;
  state_t state;
  logic [2:0] bcnt;
  logic [7:0] wcnt, wcnt_nxt;
  logic freeze, hazard, lstall;
  assign freeze = dmem_req & ~dmem_ack;
  assign hazard = mem2reg_idex & rf_wen_idex & (rf_waddr_idex != 4'd0) &
                  ((rf_waddr_idex == inst_curr_IFID_7_4_rs) |
                   (rt_used_ifid & (rf_waddr_idex == inst_curr_IFID_3_0_rt)) |
                   (store_ifid & (rf_waddr_idex == inst_curr_IFID_11_8_rd)));
  // LSTALL keeps stalling without re-checking the hazard; freeze and branch override it
  assign lstall = ~freeze & ~branch_taken_ex & ((state == RUN & hazard) | state == LSTALL);
  assign pc_wen = ~rst & ~freeze & ~lstall;
  assign ifid_wen = pc_wen;
  assign idex_wen = ~rst & ~freeze;
  assign exmem_wen = idex_wen;
  assign memwb_wen = idex_wen;
  assign ifid_flush = rst | (~freeze & branch_taken_ex);
  assign idex_flush = rst | (~freeze & (branch_taken_ex | lstall));
  assign pc_sel_branch = ~rst & ~freeze & branch_taken_ex;
  assign wcnt_nxt = freeze ? (wcnt == 8'hFF ? wcnt : wcnt + 8'd1) : 8'd0;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
      bcnt <= 3'd0;
      wcnt <= 8'd0;
      stall_cycles <= 16'd0;
      mem_timeout <= 1'b0;
    end else begin
      wcnt <= wcnt_nxt;
      if (!pc_wen && stall_cycles != 16'hFFFF) stall_cycles <= stall_cycles + 16'd1;
      if (freeze && wcnt_nxt == 8'(MEM_TIMEOUT)) mem_timeout <= 1'b1;
      if (!freeze) begin
        if (branch_taken_ex) begin
          state <= RUN;
          bcnt <= 3'd0;
        end else if (state == RUN && hazard && LOAD_USE_BUBBLES > 1) begin
          state <= LSTALL;
          bcnt <= 3'(LOAD_USE_BUBBLES - 1);
        end else if (state == LSTALL) begin
          state <= (bcnt == 3'd1) ? RUN : LSTALL;
          bcnt <= bcnt - 3'd1;
        end
      end
    end
  end
endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// tb_hazard_stall_ctrl: directed vectors with hand-computed expectations for hazard_stall_ctrl
module tb_hazard_stall_ctrl;
  logic clk = 1'b0;
  logic rst;
  logic [3:0] rs, rt, rd, waddr;
  logic rt_used, store, rf_wen, mem2reg, branch, dmem_req, dmem_ack;
  logic pc_wen, ifid_wen, idex_wen, exmem_wen, memwb_wen, ifid_flush, idex_flush, pc_sel_branch;
  logic [15:0] stall_cycles;
  logic mem_timeout;
  logic [7:0] outs;
  int total = 0;
  int passed = 0;
  localparam logic [7:0] NORM = 8'hF8, STALL = 8'h3A, FRZ = 8'h00, BR = 8'hFF, RSTV = 8'h06;
  always #5 clk = ~clk;
  hazard_stall_ctrl dut (
    .clk(clk), .rst(rst),
    .inst_curr_IFID_7_4_rs(rs), .inst_curr_IFID_3_0_rt(rt), .inst_curr_IFID_11_8_rd(rd),
    .rt_used_ifid(rt_used), .store_ifid(store), .rf_waddr_idex(waddr), .rf_wen_idex(rf_wen),
    .mem2reg_idex(mem2reg), .branch_taken_ex(branch), .dmem_req(dmem_req), .dmem_ack(dmem_ack),
    .pc_wen(pc_wen), .ifid_wen(ifid_wen), .idex_wen(idex_wen), .exmem_wen(exmem_wen),
    .memwb_wen(memwb_wen), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
    .pc_sel_branch(pc_sel_branch), .stall_cycles(stall_cycles), .mem_timeout(mem_timeout)
  );
  assign outs = {pc_wen, ifid_wen, idex_wen, exmem_wen, memwb_wen, ifid_flush, idex_flush, pc_sel_branch};
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic ld(input logic [3:0] wa, input logic [3:0] s, input logic [3:0] t, input logic [3:0] d,
                    input logic tu, input logic st);
    waddr = wa; rs = s; rt = t; rd = d; rt_used = tu; store = st; mem2reg = 1'b1; rf_wen = 1'b1;
  endtask
  task automatic clr();
    mem2reg = 1'b0; rf_wen = 1'b0; store = 1'b0; rt_used = 1'b0;
  endtask
  initial begin
    rst = 1'b1; rs = 0; rt = 0; rd = 0; waddr = 0;
    rt_used = 0; store = 0; rf_wen = 0; mem2reg = 0; branch = 0; dmem_req = 0; dmem_ack = 0;
    step(); step();
    chk("rst_outs", 32'(outs), 32'(RSTV));
    chk("rst_stall_cycles", 32'(stall_cycles), 0);
    chk("rst_timeout", 32'(mem_timeout), 0);
    rst = 1'b0; #1;
    chk("idle_norm", 32'(outs), 32'(NORM));
    ld(4'd3, 4'd3, 4'd1, 4'd5, 1'b1, 1'b0); #1;
    chk("lu_rs_c0", 32'(outs), 32'(STALL));
    step();
    chk("lu_rs_c1", 32'(outs), 32'(STALL));
    step(); clr(); #1;
    chk("lu_rs_done", 32'(outs), 32'(NORM));
    chk("lu_rs_cycles", 32'(stall_cycles), 2);
    ld(4'd4, 4'd1, 4'd2, 4'd4, 1'b0, 1'b1); #1;
    chk("lu_st_c0", 32'(outs), 32'(STALL));
    step();
    chk("lu_st_c1", 32'(outs), 32'(STALL));
    step(); clr(); #1;
    chk("lu_st_done", 32'(outs), 32'(NORM));
    chk("lu_st_cycles", 32'(stall_cycles), 4);
    ld(4'd0, 4'd0, 4'd0, 4'd0, 1'b1, 1'b1); #1;
    chk("r0_no_stall", 32'(outs), 32'(NORM));
    ld(4'd5, 4'd1, 4'd5, 4'd2, 1'b0, 1'b0); #1;
    chk("rt_unused_no_stall", 32'(outs), 32'(NORM));
    ld(4'd5, 4'd1, 4'd5, 4'd2, 1'b1, 1'b0); rf_wen = 1'b0; #1;
    chk("no_rf_wen_no_stall", 32'(outs), 32'(NORM));
    clr(); dmem_req = 1'b1; dmem_ack = 1'b1; #1;
    chk("req_ack_no_freeze", 32'(outs), 32'(NORM));
    step(); dmem_req = 1'b0; dmem_ack = 1'b0;
    chk("req_ack_cycles", 32'(stall_cycles), 4);
    ld(4'd7, 4'd7, 4'd0, 4'd0, 1'b0, 1'b0); #1;
    chk("lf_detect", 32'(outs), 32'(STALL));
    step(); dmem_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1; chk($sformatf("lf_freeze%0d", i), 32'(outs), 32'(FRZ));
      step();
    end
    dmem_req = 1'b0; #1;
    chk("lf_resume", 32'(outs), 32'(STALL));
    step(); clr(); #1;
    chk("lf_done", 32'(outs), 32'(NORM));
    chk("lf_cycles", 32'(stall_cycles), 9);
    ld(4'd6, 4'd6, 4'd0, 4'd0, 1'b0, 1'b0); #1;
    chk("br_detect", 32'(outs), 32'(STALL));
    step(); branch = 1'b1; #1;
    chk("br_in_lstall", 32'(outs), 32'(BR));
    step(); branch = 1'b0; clr(); #1;
    chk("br_next_run", 32'(outs), 32'(NORM));
    chk("br_cycles", 32'(stall_cycles), 10);
    branch = 1'b1; dmem_req = 1'b1; #1;
    chk("freeze_over_branch", 32'(outs), 32'(FRZ));
    step(); branch = 1'b0; dmem_req = 1'b0; #1;
    chk("fob_cycles", 32'(stall_cycles), 11);
    ld(4'd9, 4'd9, 4'd0, 4'd0, 1'b0, 1'b0); #1;
    chk("rs_detect", 32'(outs), 32'(STALL));
    step(); rst = 1'b1; #1;
    chk("rs_mid_stall", 32'(outs), 32'(RSTV));
    step(); rst = 1'b0; clr(); #1;
    chk("rs_after", 32'(outs), 32'(NORM));
    chk("rs_cycles", 32'(stall_cycles), 0);
    step();
    chk("rs_after2", 32'(outs), 32'(NORM));
    dmem_req = 1'b1;
    for (int i = 0; i < 63; i++) step();
    chk("to_edge63", 32'(mem_timeout), 0);
    step();
    chk("to_edge64", 32'(mem_timeout), 1);
    dmem_ack = 1'b1; #1;
    chk("to_ack_norm", 32'(outs), 32'(NORM));
    step(); dmem_req = 1'b0; dmem_ack = 1'b0;
    chk("to_sticky", 32'(mem_timeout), 1);
    chk("to_cycles", 32'(stall_cycles), 64);
    dmem_req = 1'b1;
    for (int i = 0; i < 65471; i++) step();
    chk("sat_reach", 32'(stall_cycles), 32'hFFFF);
    step(); step();
    chk("sat_hold", 32'(stall_cycles), 32'hFFFF);
    dmem_req = 1'b0; rst = 1'b1;
    step(); rst = 1'b0; #1;
    chk("to_cleared", 32'(mem_timeout), 0);
    chk("sat_cleared", 32'(stall_cycles), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
